// File: rtl/ram_sync_clr_if.sv
// Access bus for ram_sync_clr: enable/strobes, address, data and the clear handshake.
interface ram_sync_clr_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned AW = 12
);
    logic          e;
    logic          w;
    logic          r;
    logic [AW-1:0] addr;
    logic [W-1:0]  DIn;
    logic          clr;
    logic [W-1:0]  DOut;
    logic          rv;
    logic          busy;

    modport master (
        output e, w, r, addr, DIn, clr,
        input  DOut, rv, busy
    );

    modport slave (
        input  e, w, r, addr, DIn, clr,
        output DOut, rv, busy
    );
endinterface

// File: rtl/ram_sync_clr.sv
// Single-port word RAM with registered read, read-valid strobe and a clear sequencer
// that writes zero to every location after reset (RST_CLR=1) or on a clr pulse.
module ram_sync_clr #(
    parameter int unsigned W       = 16,
    parameter int unsigned AW      = 12,
    parameter bit          RST_CLR = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    ram_sync_clr_if.slave      bus
);
    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {
        StIdle,
        StClear
    } state_t;

    // Reset lands in the clear sequence only when auto-clear is enabled.
    localparam state_t RstState = RST_CLR ? StClear : StIdle;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dout_q;
    logic          rv_q;

    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          re;

    logic [W-1:0]  mem [DEPTH];

    // Next-state and array-port decode; accesses only act in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = bus.addr;
        wdata   = bus.DIn;
        re      = 1'b0;
        unique case (state_q)
            StIdle: begin
                we = bus.e & bus.w;
                re = bus.e & bus.r;
                // The access in the clr cycle still completes.
                if (bus.clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state and registered read port; read uses pre-write contents (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RstState;
            cnt_q   <= '0;
            dout_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv_q    <= re;
            if (re) begin
                dout_q <= mem[bus.addr];
            end
        end
    end

    // Memory array; deliberately not reset, only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        bus.DOut = dout_q;
        bus.rv   = rv_q;
        bus.busy = (state_q == StClear);
    end
endmodule

// File: tb/tb_ram_sync_clr.sv
// Bench for ram_sync_clr: small auto-clearing instance (AW=3) and a default-size
// instance without auto-clear; read results are checked against a queue of expected words.
module tb_ram_sync_clr;
    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_a [8];
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    logic [15:0] last_dout;

    ram_sync_clr_if #(.W(16), .AW(3))  bus_a ();
    ram_sync_clr_if #(.W(16), .AW(12)) bus_b ();

    ram_sync_clr #(.W(16), .AW(3), .RST_CLR(1'b1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    ram_sync_clr #(.W(16), .AW(12), .RST_CLR(1'b0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on instance A; the model records the expected read (old data) before the write.
    task automatic drive_a(input logic e, input logic w, input logic r, input logic [2:0] a,
                           input logic [15:0] d, input logic c);
        bus_a.e    = e;
        bus_a.w    = w;
        bus_a.r    = r;
        bus_a.addr = a;
        bus_a.DIn  = d;
        bus_a.clr  = c;
        if (e && r) exp_q.push_back(model_a[a]);
        if (e && w) model_a[a] = d;
        step();
    endtask

    task automatic test_reset();
        int nb;
        #2;
        n_checks++;
        if (bus_a.busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b want 1", bus_a.busy);
        end
        n_checks++;
        if (bus_a.rv !== 1'b0) begin
            n_fail++; $display("FAIL reset_rv: got %b want 0", bus_a.rv);
        end
        n_checks++;
        if (bus_a.DOut !== 16'h0000) begin
            n_fail++; $display("FAIL reset_dout: got %h want 0000", bus_a.DOut);
        end
        step();
        step();
        rst_a = 1'b0;
        nb = 0;
        while (bus_a.busy === 1'b1 && nb < 40) begin
            step();
            nb++;
        end
        n_checks++;
        if (nb != 8) begin
            n_fail++; $display("FAIL reset_clear_len: got %0d cycles want 8", nb);
        end
        for (int i = 0; i < 8; i++) model_a[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b0, 1'b1, 3'(i), 16'h0, 1'b0);
            n_checks++;
            if (bus_a.rv !== 1'b1) begin
                n_fail++; $display("FAIL reset_read_rv[%0d]: got %b want 1", i, bus_a.rv);
            end
            exp_v = exp_q.pop_front();
            n_checks++;
            if (bus_a.DOut !== exp_v) begin
                n_fail++; $display("FAIL reset_read_data[%0d]: got %h want %h", i, bus_a.DOut, exp_v);
            end
        end
        drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic test_write_read();
        drive_a(1'b1, 1'b1, 1'b0, 3'd3, 16'hA5A5, 1'b0);
        n_checks++;
        if (bus_a.rv !== 1'b0) begin
            n_fail++; $display("FAIL write_rv: got %b want 0", bus_a.rv);
        end
        drive_a(1'b1, 1'b1, 1'b0, 3'd7, 16'h1234, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1, 3'd3, 16'h0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1, 3'd7, 16'h0, 1'b0);
        n_checks++;
        if (bus_a.rv !== 1'b1) begin
            n_fail++; $display("FAIL b2b_rv: got %b want 1", bus_a.rv);
        end
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus_a.DOut !== exp_v) begin
            n_fail++; $display("FAIL b2b_second: got %h want %h", bus_a.DOut, exp_v);
        end
        last_dout = exp_v;
        drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        n_checks++;
        if (bus_a.rv !== 1'b0) begin
            n_fail++; $display("FAIL idle_rv: got %b want 0", bus_a.rv);
        end
        n_checks++;
        if (bus_a.DOut !== last_dout) begin
            n_fail++; $display("FAIL dout_hold: got %h want %h", bus_a.DOut, last_dout);
        end
    endtask

    task automatic test_back_to_back();
        // First read of the pair (addr 3) checked here with rv held across both cycles.
        drive_a(1'b1, 1'b0, 1'b1, 3'd3, 16'h0, 1'b0);
        n_checks++;
        if (bus_a.rv !== 1'b1 || bus_a.DOut !== exp_q[0]) begin
            n_fail++; $display("FAIL b2b_first: got rv=%b %h want rv=1 %h", bus_a.rv, bus_a.DOut, exp_q[0]);
        end
        void'(exp_q.pop_front());
        drive_a(1'b1, 1'b0, 1'b1, 3'd7, 16'h0, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus_a.rv !== 1'b1 || bus_a.DOut !== exp_v) begin
            n_fail++; $display("FAIL b2b_next: got rv=%b %h want rv=1 %h", bus_a.rv, bus_a.DOut, exp_v);
        end
        drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic test_read_first();
        drive_a(1'b1, 1'b1, 1'b0, 3'd5, 16'h00FF, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus_a.rv !== 1'b1 || bus_a.DOut !== exp_v) begin
            n_fail++; $display("FAIL read_first_old: got rv=%b %h want rv=1 %h", bus_a.rv, bus_a.DOut, exp_v);
        end
        drive_a(1'b1, 1'b0, 1'b1, 3'd5, 16'h0, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus_a.rv !== 1'b1 || bus_a.DOut !== exp_v) begin
            n_fail++; $display("FAIL read_first_new: got rv=%b %h want rv=1 %h", bus_a.rv, bus_a.DOut, exp_v);
        end
        drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic test_cmd_clear();
        int nb;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b1, 1'b0, 3'(i), 16'(16'h1111 * (i + 1)), 1'b0);
        end
        drive_a(1'b1, 1'b1, 1'b0, 3'd2, 16'h7777, 1'b1);
        nb = 0;
        while (bus_a.busy === 1'b1 && nb < 40) begin
            nb++;
            bus_a.e    = 1'b1;
            bus_a.w    = 1'b1;
            bus_a.r    = 1'b1;
            bus_a.clr  = 1'b1;
            bus_a.addr = 3'(nb);
            bus_a.DIn  = 16'hDEAD;
            step();
            n_checks++;
            if (bus_a.rv !== 1'b0) begin
                n_fail++; $display("FAIL clear_rv[%0d]: got %b want 0", nb, bus_a.rv);
            end
        end
        n_checks++;
        if (nb != 8) begin
            n_fail++; $display("FAIL clear_len: got %0d cycles want 8", nb);
        end
        for (int i = 0; i < 8; i++) model_a[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b0, 1'b1, 3'(i), 16'h0, 1'b0);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (bus_a.rv !== 1'b1 || bus_a.DOut !== exp_v) begin
                n_fail++; $display("FAIL clear_read[%0d]: got rv=%b %h want rv=1 %h", i, bus_a.rv, bus_a.DOut, exp_v);
            end
        end
        drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic test_reset_mid_clear();
        int nb;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b1, 1'b0, 3'(i), 16'(16'h0101 * (i + 3)), 1'b0);
        end
        drive_a(1'b1, 1'b0, 1'b1, 3'd1, 16'h0, 1'b0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus_a.DOut !== exp_v) begin
            n_fail++; $display("FAIL mid_pre_read: got %h want %h", bus_a.DOut, exp_v);
        end
        drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        bus_a.clr = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_a = 1'b1;
        #1;
        n_checks++;
        if (bus_a.DOut !== 16'h0000 || bus_a.rv !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_outputs: got %h rv=%b want 0000 rv=0", bus_a.DOut, bus_a.rv);
        end
        n_checks++;
        if (bus_a.busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_busy: got %b want 1", bus_a.busy);
        end
        step();
        rst_a = 1'b0;
        nb = 0;
        while (bus_a.busy === 1'b1 && nb < 40) begin
            step();
            nb++;
        end
        n_checks++;
        if (nb != 8) begin
            n_fail++; $display("FAIL mid_clear_len: got %0d cycles want 8", nb);
        end
        for (int i = 0; i < 8; i++) model_a[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 1'b0, 1'b1, 3'(i), 16'h0, 1'b0);
            exp_v = exp_q.pop_front();
            n_checks++;
            if (bus_a.rv !== 1'b1 || bus_a.DOut !== exp_v) begin
                n_fail++; $display("FAIL mid_read[%0d]: got rv=%b %h want rv=1 %h", i, bus_a.rv, bus_a.DOut, exp_v);
            end
        end
        drive_a(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic test_no_rst_clr();
        n_checks++;
        if (bus_b.busy !== 1'b0 || bus_b.DOut !== 16'h0000 || bus_b.rv !== 1'b0) begin
            n_fail++; $display("FAIL b_reset: got busy=%b %h rv=%b want busy=0 0000 rv=0", bus_b.busy, bus_b.DOut, bus_b.rv);
        end
        rst_b = 1'b0;
        step();
        n_checks++;
        if (bus_b.busy !== 1'b0) begin
            n_fail++; $display("FAIL b_busy_after_rst: got %b want 0", bus_b.busy);
        end
        bus_b.e = 1'b1; bus_b.w = 1'b1; bus_b.r = 1'b0; bus_b.addr = 12'hFFF; bus_b.DIn = 16'hFFFF;
        step();
        bus_b.addr = 12'h000; bus_b.DIn = 16'h0001;
        step();
        bus_b.w = 1'b0; bus_b.r = 1'b1; bus_b.addr = 12'hFFF;
        exp_q.push_back(16'hFFFF);
        step();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus_b.rv !== 1'b1 || bus_b.DOut !== exp_v) begin
            n_fail++; $display("FAIL b_read_top: got rv=%b %h want rv=1 %h", bus_b.rv, bus_b.DOut, exp_v);
        end
        bus_b.addr = 12'h000;
        exp_q.push_back(16'h0001);
        step();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus_b.rv !== 1'b1 || bus_b.DOut !== exp_v) begin
            n_fail++; $display("FAIL b_read_zero: got rv=%b %h want rv=1 %h", bus_b.rv, bus_b.DOut, exp_v);
        end
        bus_b.e = 1'b0; bus_b.r = 1'b0;
        step();
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.e = 1'b0; bus_a.w = 1'b0; bus_a.r = 1'b0;
        bus_a.addr = '0; bus_a.DIn = '0; bus_a.clr = 1'b0;
        bus_b.e = 1'b0; bus_b.w = 1'b0; bus_b.r = 1'b0;
        bus_b.addr = '0; bus_b.DIn = '0; bus_b.clr = 1'b0;
        last_dout = '0;
        for (int i = 0; i < 8; i++) model_a[i] = 16'h0000;

        test_reset();
        test_write_read();
        test_back_to_back();
        test_read_first();
        test_cmd_clear();
        test_reset_mid_clear();
        test_no_rst_clr();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
